multibyte_add_seq: RTL and testbench
====================================

// Module: multibyte_add_seq
// PURPOSE
//   Sequences a shared external 8-bit adder (Ain/Bin/Ci -> Result/Co) to perform
//   one NBYTES-wide add per request, one byte per clock, LSB first, chaining carry.
//   Accumulates the same status flags the post-processor derives per byte (OV, Z, N)
//   over the full word. Sits between a valid/ready requester and the 8-bit adder.
// PARAMETERS
//   NBYTES   4   operand width in bytes (>=1); operand/result width = 8*NBYTES
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   req_valid  in   1           request present
//   req_ready  out  1           block can accept a request (IDLE only)
//   req_a      in   8*NBYTES    operand A
//   req_b      in   8*NBYTES    operand B
//   req_ci     in   1           carry-in to byte 0
//   add_a      out  8           to adder Ain
//   add_b      out  8           to adder Bin
//   add_ci     out  1           to adder Ci
//   add_sum    in   8           from adder Result (combinational, same cycle)
//   add_co     in   1           from adder Co
//   res_valid  out  1           result available
//   res_ready  in   1           consumer takes result
//   res_sum    out  8*NBYTES    full-width sum
//   res_co     out  1           carry-out of top byte
//   res_ov     out  1           signed overflow of full word
//   res_z      out  1           full-word result == 0
//   res_n      out  1           res_sum[8*NBYTES-1]
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; req_ready=1 after reset; res_valid=0;
//     res_sum=0, res_co/ov/z/n=0; byte index=0; carry reg=0. Reset mid-RUN or in
//     DONE aborts the operation, no result is produced.
//   - FSM IDLE -> RUN on req_valid&req_ready: latch req_a/req_b, carry<=req_ci,
//     idx<=0, z_acc<=1. RUN: add_a/add_b = byte idx of latched A/B, add_ci = carry;
//     each edge: res_sum byte idx<=add_sum, carry<=add_co, z_acc&=(add_sum==0),
//     idx++. On idx==NBYTES-1 edge: res_co<=add_co, res_n<=add_sum[7],
//     res_ov<=(A_top[7]==B_top[7])&(add_sum[7]!=A_top[7]), res_z<=z_acc&(add_sum==0),
//     -> DONE. DONE: res_valid=1; on res_ready -> IDLE.
//   - Latency: accept edge k; res_valid high from cycle after edge k+NBYTES.
//     NBYTES=1: RUN lasts one cycle.
//   - Outside RUN: add_a=0, add_b=0, add_ci=0 (adder idle, flags quiet).
//   - req_ready=1 only in IDLE; req_valid in RUN/DONE ignored, operands not sampled.
//   - res_* registered, stable throughout DONE regardless of res_ready stall length;
//     res_sum bytes retain last result in IDLE until overwritten by the next RUN.
//   - Carry chains across bytes only; no wrap beyond top byte (carry -> res_co).
// CONFIGURATION
//   SUB_MODE_EN defined: extra input port req_sub (1 bit, latched on accept).
//     req_sub=1: add_b = ~B byte, initial carry forced 1 (req_ci ignored) -> A-B;
//     res_co=1 means no borrow; res_ov uses inverted B top bit. req_sub=0: add.
//   SUB_MODE_EN undefined: no req_sub port; add only, add_b = B byte.
// TESTING (NBYTES=4)
//   A=0x000000FF,B=0x00000001,ci=0 -> sum 0x00000100, co0 ov0 z0 n0, valid 4 cyc after accept
//   A=0x7FFFFFFF,B=0x00000001,ci=0 -> sum 0x80000000, co0 ov1 z0 n1
//   A=0xFFFFFFFF,B=0x00000001,ci=0 -> sum 0x00000000, co1 ov0 z1 n0; A=B=0,ci=1 -> sum 1, z0
//   res_ready low 5 cycles in DONE -> res_* stable, req_ready=0, new req_valid ignored
//   rst_n low during RUN idx=2 -> immediate IDLE, res_valid=0, outputs 0, next req normal
//   SUB_MODE_EN: A=5,B=7,sub=1 -> sum 0xFFFFFFFE, co0 ov0 n1; A=0x80000000,B=1 -> ov1

Source files
------------

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq
//   Drives a shared external 8-bit adder to build one NBYTES-wide addition per
//   request. Bytes are processed LSB first, one per clock, and the carry is
//   chained from byte to byte. Full-word status flags are collected along the
//   way: signed overflow, zero and negative.
//
// Optional feature, controlled by the macro SUB_MODE_EN:
//   When the macro is defined, the block gains a req_sub input.
//   When req_sub is set, the block computes A-B instead of A+B, using the
//   two's-complement form A + ~B + 1. When the macro is undefined, the block
//   only adds.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   req_valid/ready    request handshake; ready is high only while idle
//   req_a, req_b       operands, 8*NBYTES bits wide
//   req_ci             carry into byte 0
//   req_sub            subtract select (only when SUB_MODE_EN is defined)
//   add_a/b/ci         operands sent to the external adder; held at zero when idle
//   add_sum/co         adder result, combinational in the same cycle
//   res_valid/ready    result handshake
//   res_sum            full-width sum
//   res_co             carry out of the top byte
//   res_ov, res_z, res_n  overflow, zero and negative flags for the full word
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_ci,
`ifdef SUB_MODE_EN
  input  logic                  req_sub,
`endif
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_ci,
  input  logic [7:0]            add_sum,
  input  logic                  add_co,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_co,
  output logic                  res_ov,
  output logic                  res_z,
  output logic                  res_n
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic            zacc_q;
  logic            co_q;
  logic            ov_q;
  logic            z_q;
  logic            n_q;
  logic            opSub;

`ifdef SUB_MODE_EN
  logic            sub_q;
  assign opSub = sub_q;
`else
  assign opSub = 1'b0;
`endif

  logic [7:0] aByte;
  logic [7:0] bByte;
  logic [7:0] bOpByte;
  logic       aTop;
  logic       bTopOp;
  logic       sumZero;
  logic       startCarry;

  // Select the current byte of each latched operand. For a subtraction, B is
  // inverted here; the +1 of the two's complement enters as the initial carry.
  always_comb begin
    aByte      = a_q[8*idx_q +: 8];
    bByte      = b_q[8*idx_q +: 8];
    bOpByte    = opSub ? ~bByte : bByte;
    aTop       = a_q[W-1];
    bTopOp     = b_q[W-1] ^ opSub;
    sumZero    = (add_sum == 8'h00);
`ifdef SUB_MODE_EN
    startCarry = req_sub ? 1'b1 : req_ci;
`else
    startCarry = req_ci;
`endif
  end

  // The adder inputs are forced to zero outside RUN so the shared adder and
  // its flags stay quiet.
  always_comb begin
    add_a  = 8'h00;
    add_b  = 8'h00;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = aByte;
      add_b  = bOpByte;
      add_ci = carry_q;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign res_sum   = sum_q;
  assign res_co    = co_q;
  assign res_ov    = ov_q;
  assign res_z     = z_q;
  assign res_n     = n_q;

  // Sequencer. The final byte's flags are computed straight from the adder
  // output, so the result can be presented on the cycle after the last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef SUB_MODE_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            carry_q <= startCarry;
            idx_q   <= '0;
            zacc_q  <= 1'b1;
`ifdef SUB_MODE_EN
            sub_q   <= req_sub;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[8*idx_q +: 8] <= add_sum;
          carry_q             <= add_co;
          zacc_q              <= zacc_q & sumZero;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            co_q    <= add_co;
            n_q     <= add_sum[7];
            ov_q    <= (aTop == bTopOp) & (add_sum[7] != aTop);
            z_q     <= zacc_q & sumZero;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Testbench for multibyte_add_seq with NBYTES=4.
// The environment provides a behavioural 8-bit adder. Results are compared
// with a full-word arithmetic model that works on whole 32-bit words.
module tb_multibyte_add_seq;

  localparam int NBYTES = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ci;
  logic        reqSub;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_ci;
  logic [7:0]  add_sum;
  logic        add_co;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_sum;
  logic        res_co;
  logic        res_ov;
  logic        res_z;
  logic        res_n;

  int nCompared;
  int nMismatched;

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ci    (req_ci),
`ifdef SUB_MODE_EN
    .req_sub   (reqSub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_sum   (add_sum),
    .add_co    (add_co),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_co    (res_co),
    .res_ov    (res_ov),
    .res_z     (res_z),
    .res_n     (res_n)
  );

  // The external 8-bit adder, modelled as combinational logic
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Word-level reference: returns {sum[31:0], co, ov, z, n}
  function automatic logic [35:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input logic sub);
    longint unsigned u;
    longint          s;
    logic [31:0]     sum;
    logic            co;
    logic            ov;
    if (sub) begin
      sum = a - b;
      co  = (a >= b);
      s   = longint'($signed(a)) - longint'($signed(b));
    end else begin
      u   = 64'(a) + 64'(b) + 64'(ci);
      sum = u[31:0];
      co  = (u > 64'h0000_0000_FFFF_FFFF);
      s   = longint'($signed(a)) + longint'($signed(b)) + (ci ? 64'sd1 : 64'sd0);
    end
    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {sum, co, ov, (sum == 32'h0), sum[31]};
  endfunction

  // Runs one transaction end to end. During the result stall, the task drives
  // a distracting request that must be ignored.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic ci, input logic sub, input int stall);
    logic [35:0] exp;
    int          cnt;
    exp = refModel(a, b, ci, sub);
    @(negedge clk);
    checkOutput("req_ready idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_ci    = ci;
    reqSub    = sub;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_ci    = 1'($urandom);
    checkOutput("add_a byte0", 64'(add_a), 64'(a[7:0]));
    checkOutput("add_ci first", 64'(add_ci), 64'(sub ? 1'b1 : ci));
    cnt = 0;
    while (!res_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("latency", 64'(cnt), 64'(NBYTES));
    checkOutput("res_sum", 64'(res_sum), 64'(exp[35:4]));
    checkOutput("flags co/ov/z/n", 64'({res_co, res_ov, res_z, res_n}), 64'(exp[3:0]));
    checkOutput("add_a quiet DONE", 64'({add_a, add_b, add_ci}), 64'd0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      checkOutput("stall res_valid", 64'(res_valid), 64'd1);
      checkOutput("stall req_ready", 64'(req_ready), 64'd0);
      checkOutput("stall res", 64'({res_sum, res_co, res_ov, res_z, res_n}), 64'(exp));
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("back idle", 64'({req_ready, res_valid}), 64'b10);
    checkOutput("sum retained", 64'(res_sum), 64'(exp[35:4]));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rsub;
    nCompared   = 0;
    nMismatched = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_ci    = 1'b0;
    reqSub    = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset handshake", 64'({req_ready, res_valid}), 64'b10);
    checkOutput("reset res", 64'({res_sum, res_co, res_ov, res_z, res_n}), 64'd0);
    checkOutput("reset adder", 64'({add_a, add_b, add_ci}), 64'd0);
    rst_n = 1'b1;

    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
    applyStimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 5);

    // Reset while idx=2: the operation is aborted and no result appears
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h0102_0304;
    req_ci    = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort handshake", 64'({req_ready, res_valid}), 64'b10);
    checkOutput("abort res", 64'({res_sum, res_co, res_ov, res_z, res_n}), 64'd0);
    checkOutput("abort adder", 64'({add_a, add_b, add_ci}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort no result", 64'(res_valid), 64'd0);
    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 0);

`ifdef SUB_MODE_EN
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1);
`endif

    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t % 8 == 0) rb = ~ra;
`ifdef SUB_MODE_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      applyStimulus(ra, rb, 1'($urandom), rsub, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
